// File: rtl/spi_cmd_seq.sv
// Command sequencer in front of the SPI master: queues 14-bit command words,
// issues them one at a time, and returns each read byte (or a timeout marker).
module spi_cmd_seq #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [13:0] i_cmd_data,
    input  logic        i_cmd_sel,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    output logic [7:0]  o_rsp_data,
    output logic        o_rsp_sel,
    output logic        o_rsp_timeout,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [13:0] o_m_data_in,
    output logic        o_m_cs_sel,
    output logic        o_m_tx_valid,
    input  logic        i_m_rx_ready,
    input  logic [7:0]  i_m_data_out,
    output logic        o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACC,
        WAIT_DONE
    } state_t;

    state_t        r_state;
    logic [14:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_tmo;
    logic [13:0]   r_m_data_in;
    logic          r_m_cs_sel;
    logic          r_m_tx_valid;
    logic [7:0]    r_rsp_data;
    logic          r_rsp_sel;
    logic          r_rsp_timeout;
    logic          r_rsp_valid;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_slot_free;
    logic          w_start;
    logic [14:0]   w_head;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = i_cmd_valid && !w_full;
    assign w_slot_free = !r_rsp_valid || i_rsp_ready;
    assign w_start     = (r_state == IDLE) && !w_empty && w_slot_free;
    assign w_head      = r_mem[r_rptr];

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_cmd_sel, i_cmd_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_tmo         <= '0;
            r_m_data_in   <= '0;
            r_m_cs_sel    <= 1'b0;
            r_m_tx_valid  <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_sel     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_start) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_start})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_m_tx_valid <= 1'b0;
            // A response loaded below on the same edge overrides this clear.
            if (r_rsp_valid && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_m_data_in  <= w_head[13:0];
                        r_m_cs_sel   <= w_head[14];
                        r_m_tx_valid <= 1'b1;
                        r_tmo        <= '0;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT_ACC;
                end
                WAIT_ACC, WAIT_DONE: begin
                    if (r_state == WAIT_DONE && i_m_rx_ready) begin
                        r_rsp_data    <= i_m_data_out;
                        r_rsp_sel     <= r_m_cs_sel;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= IDLE;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_rsp_data    <= '0;
                        r_rsp_sel     <= r_m_cs_sel;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (r_state == WAIT_ACC && !i_m_rx_ready) begin
                            r_state <= WAIT_DONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cmd_ready   = !w_full;
    assign o_busy        = (r_state != IDLE);
    assign o_m_data_in   = r_m_data_in;
    assign o_m_cs_sel    = r_m_cs_sel;
    assign o_m_tx_valid  = r_m_tx_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_sel     = r_rsp_sel;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_rsp_valid   = r_rsp_valid;

endmodule
